// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the 16-bit core control sequencer.
// Covers the state encoding, the opcode width and the opcodes the sequencer
// handles specially. All other opcodes are ALU operations.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_LOAD  = 4'hC;
    localparam opcode_t OP_STORE = 4'hD;
    localparam opcode_t OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_REGREAD = 3'd2,
        S_ALU     = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    // True for opcodes that need a data-memory access after the ALU stage.
    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// Stage-enable and memory-handshake bundle between the control sequencer
// and the rest of the core.
// The sequencer drives the bundle through the master modport. The datapath and
// memory use the slave modport.
// When CTRL_PERF_CNT_EN is defined, the bundle also carries the
// retired-instruction count.
interface cpu_ctrl_sequencer_if
    import cpu_ctrl_pkg::*;
`ifdef CTRL_PERF_CNT_EN
    #(parameter int CNT_W = 16)
`endif
    ();

    opcode_t opcode;       // decoder output, meaningful from REGREAD onward
    logic    mem_ready;    // memory completes the current request
    logic    en_fetch;
    logic    en_decode;
    logic    en_regread;
    logic    en_alu;
    logic    en_regwrite;
    logic    mem_req;
    logic    mem_we;
    logic    pc_inc;
    logic    halted;
    logic    error;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired;
`endif

    modport master (
        input  opcode,
        input  mem_ready,
        output en_fetch,
        output en_decode,
        output en_regread,
        output en_alu,
        output en_regwrite,
        output mem_req,
        output mem_we,
        output pc_inc,
        output halted,
`ifdef CTRL_PERF_CNT_EN
        output retired,
`endif
        output error
    );

    modport slave (
        output opcode,
        output mem_ready,
        input  en_fetch,
        input  en_decode,
        input  en_regread,
        input  en_alu,
        input  en_regwrite,
        input  mem_req,
        input  mem_we,
        input  pc_inc,
        input  halted,
`ifdef CTRL_PERF_CNT_EN
        input  retired,
`endif
        input  error
    );

endinterface

// File: rtl/cpu_ctrl_wait_timer.sv
// Memory wait timer for the control sequencer.
// The timer counts the cycles in which a request is outstanding and not yet
// accepted. It flags the cycle in which the count has reached MEM_TIMEOUT while
// memory is still not ready.
// A ready in the limit cycle is therefore still accepted.
// When MEM_TIMEOUT is 0, the timer never fires.
module cpu_ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic wait_cycle,   // mem_req high and mem_ready low this cycle
    input  logic clear,        // sequencer changes state at the next edge
    output logic limit_hit
);

    localparam int CNT_BITS = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(MEM_TIMEOUT);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [CNT_BITS-1:0] wait_cnt_reg;

    assign limit_hit = TIMEOUT_EN && wait_cycle && (wait_cnt_reg == LIMIT);

    // Count unanswered request cycles and saturate at the limit.
    // The count restarts whenever the sequencer leaves its current state.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wait_cnt_reg <= '0;
        end else if (TIMEOUT_EN && wait_cycle && (wait_cnt_reg != LIMIT)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle control sequencer for the 16-bit core.
// The sequencer steps through FETCH, DECODE, REGREAD, ALU, optionally MEM, and
// then WB.
// It pulses one stage enable per cycle and runs the memory req/ready handshake.
// It parks in HALT on the halt opcode or on a memory timeout.
// Optional feature macro: CTRL_PERF_CNT_EN adds the retired-instruction counter.
module cpu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu_ctrl_sequencer_if.master bus
);

    state_t state_reg;
    state_t state_next;

    logic en_fetch_reg;
    logic en_decode_reg;
    logic en_regread_reg;
    logic en_alu_reg;
    logic en_regwrite_reg;
    logic mem_req_reg;
    logic mem_we_reg;
    logic pc_inc_reg;
    logic halted_reg;
    logic error_reg;

    logic wait_cycle;
    logic wait_limit;
    logic state_change;
    logic store_done;
    logic pc_inc;

    // The output registers are cleared by reset, so mem_req_reg is 0 in the
    // first FETCH cycle after reset.
    // A stray mem_ready in that cycle is therefore ignored, and the request
    // that follows is a fresh one.
    assign wait_cycle   = mem_req_reg && !bus.mem_ready;
    assign state_change = (state_next != state_reg);

    cpu_ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .wait_cycle (wait_cycle),
        .clear      (state_change),
        .limit_hit  (wait_limit)
    );

    // A store retires in the same cycle memory accepts it.
    // That pulse cannot come from a register, so it is combined here with the
    // WB pulse.
    assign store_done = (state_reg == S_MEM) && mem_req_reg && mem_we_reg && bus.mem_ready;
    assign pc_inc     = pc_inc_reg || store_done;

    // Next-state selection from the current state, opcode and handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_req_reg) begin
                    if (bus.mem_ready) begin
                        state_next = S_DECODE;
                    end else if (wait_limit) begin
                        state_next = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                state_next = S_REGREAD;
            end
            S_REGREAD: begin
                state_next = (bus.opcode == OP_HALT) ? S_HALT : S_ALU;
            end
            S_ALU: begin
                state_next = is_mem_op(bus.opcode) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_req_reg) begin
                    if (bus.mem_ready) begin
                        state_next = mem_we_reg ? S_FETCH : S_WB;
                    end else if (wait_limit) begin
                        state_next = S_HALT;
                    end
                end
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State register plus registered Moore outputs decoded from the state
    // being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_FETCH;
            en_fetch_reg    <= 1'b0;
            en_decode_reg   <= 1'b0;
            en_regread_reg  <= 1'b0;
            en_alu_reg      <= 1'b0;
            en_regwrite_reg <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            pc_inc_reg      <= 1'b0;
            halted_reg      <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            en_fetch_reg    <= (state_next == S_FETCH);
            en_decode_reg   <= (state_next == S_DECODE);
            en_regread_reg  <= (state_next == S_REGREAD);
            en_alu_reg      <= (state_next == S_ALU);
            en_regwrite_reg <= (state_next == S_WB);
            mem_req_reg     <= (state_next == S_FETCH) || (state_next == S_MEM);
            // Store/load direction is captured on MEM entry and held for the
            // whole access.
            mem_we_reg      <= (state_next == S_MEM) &&
                               ((state_reg == S_MEM) ? mem_we_reg : (bus.opcode == OP_STORE));
            pc_inc_reg      <= (state_next == S_WB);
            halted_reg      <= (state_next == S_HALT);
            error_reg       <= error_reg || wait_limit;
        end
    end

    assign bus.en_fetch    = en_fetch_reg;
    assign bus.en_decode   = en_decode_reg;
    assign bus.en_regread  = en_regread_reg;
    assign bus.en_alu      = en_alu_reg;
    assign bus.en_regwrite = en_regwrite_reg;
    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.pc_inc      = pc_inc;
    assign bus.halted      = halted_reg;
    assign bus.error       = error_reg;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_reg;

    // Count every retirement pulse and wrap naturally.
    // No pulses occur in HALT, so the count holds there.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (pc_inc) begin
            retired_reg <= retired_reg + 1'b1;
        end
    end

    assign bus.retired = retired_reg;
`endif

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Self-checking bench for cpu_ctrl_sequencer, built with MEM_TIMEOUT = 4.
// Directed scenarios with literal expectations run first. A randomized run
// follows, checked every cycle against an instruction-level model of the
// sequencer.
// Retired-count checks are compiled in when CTRL_PERF_CNT_EN is defined.
module tb_cpu_ctrl_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int TIMEOUT = 4;

    // Stage numbers used by the reference model.
    localparam int ST_FETCH   = 0;
    localparam int ST_DECODE  = 1;
    localparam int ST_REGREAD = 2;
    localparam int ST_ALU     = 3;
    localparam int ST_MEM     = 4;
    localparam int ST_WB      = 5;
    localparam int ST_HALT    = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    cpu_ctrl_sequencer_if bus ();

    cpu_ctrl_sequencer #(
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_active;     // 0 in the cycle right after a reset edge
    int          m_stage;
    int          m_wait;
    bit          m_err;
    logic [15:0] m_ret;

    logic [5:0] pat [5];

    // Model: advance one instruction stage per clock using the sampled inputs.
    always @(posedge clock) begin
        int nxt;
        if (reset) begin
            m_active = 1'b0;
            m_stage  = ST_FETCH;
            m_wait   = 0;
            m_err    = 1'b0;
            m_ret    = '0;
        end else if (!m_active) begin
            m_active = 1'b1;
        end else begin
            nxt = m_stage;
            case (m_stage)
                ST_FETCH, ST_MEM: begin
                    if (bus.mem_ready) begin
                        if (m_stage == ST_FETCH) begin
                            nxt = ST_DECODE;
                        end else if (bus.opcode == OP_STORE) begin
                            nxt = ST_FETCH;
                            m_ret++;
                        end else begin
                            nxt = ST_WB;
                        end
                    end else if (m_wait == TIMEOUT) begin
                        nxt   = ST_HALT;
                        m_err = 1'b1;
                    end else begin
                        m_wait++;
                    end
                end
                ST_DECODE:  nxt = ST_REGREAD;
                ST_REGREAD: nxt = (bus.opcode == OP_HALT) ? ST_HALT : ST_ALU;
                ST_ALU:     nxt = ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)) ? ST_MEM : ST_WB;
                ST_WB: begin
                    nxt = ST_FETCH;
                    m_ret++;
                end
                default:    nxt = ST_HALT;
            endcase
            if (nxt != m_stage) m_wait = 0;
            m_stage = nxt;
        end
    end

    // Expected {fetch,decode,regread,alu,regwrite,mem_req,mem_we,pc_inc,halted,error}.
    function automatic logic [9:0] model_outputs();
        logic [9:0] v;
        v = '0;
        if (m_active) begin
            v[9] = (m_stage == ST_FETCH);
            v[8] = (m_stage == ST_DECODE);
            v[7] = (m_stage == ST_REGREAD);
            v[6] = (m_stage == ST_ALU);
            v[5] = (m_stage == ST_WB);
            v[4] = (m_stage == ST_FETCH) || (m_stage == ST_MEM);
            v[3] = (m_stage == ST_MEM) && (bus.opcode == OP_STORE);
            v[2] = (m_stage == ST_WB) ||
                   ((m_stage == ST_MEM) && (bus.opcode == OP_STORE) && bus.mem_ready);
            v[1] = (m_stage == ST_HALT);
        end
        v[0] = m_err;
        return v;
    endfunction

    task automatic compare_model(input string tag);
        logic [9:0] exp_v;
        logic [9:0] act_v;
        exp_v = model_outputs();
        act_v = {bus.en_fetch, bus.en_decode, bus.en_regread, bus.en_alu, bus.en_regwrite,
                 bus.mem_req, bus.mem_we, bus.pc_inc, bus.halted, bus.error};
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s outputs: got %b required %b (model stage %0d) at %0t",
                     tag, act_v, exp_v, m_stage, $time);
        end
`ifdef CTRL_PERF_CNT_EN
        n_vec++;
        if (bus.retired !== m_ret) begin
            n_err++;
            $display("FAIL %s retired: got %0d required %0d at %0t", tag, bus.retired, m_ret, $time);
        end
`endif
    endtask

    task automatic check_lit(input string name, input int act, input int exp_val);
        n_vec++;
        if (act !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp_val, $time);
        end
    endtask

    function automatic opcode_t pick_opcode();
        int r;
        r = $urandom_range(0, 31);
        if (r == 0)  return OP_HALT;
        if (r <= 9)  return OP_LOAD;
        if (r <= 18) return OP_STORE;
        return opcode_t'($urandom_range(0, 11));
    endfunction

    // One cycle: drive inputs on the falling edge, then check one step later.
    task automatic apply(input logic rst, input logic rdy, input bit new_op, input string tag);
        @(negedge clock);
        if (new_op && m_active && (m_stage == ST_DECODE)) bus.opcode = pick_opcode();
        reset         = rst;
        bus.mem_ready = rdy;
        #1;
        compare_model(tag);
    endtask

    function automatic int stage_vec();
        return int'({bus.en_fetch, bus.en_decode, bus.en_regread, bus.en_alu,
                     bus.en_regwrite, bus.pc_inc});
    endfunction

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int halt_cycles;
        int rdy_pct;

        pat[0] = 6'b100000;
        pat[1] = 6'b010000;
        pat[2] = 6'b001000;
        pat[3] = 6'b000100;
        pat[4] = 6'b000011;

        bus.opcode    = 4'h1;
        bus.mem_ready = 1'b0;

        // Reset: every output is 0.
        apply(1'b1, 1'b1, 1'b0, "reset");
        apply(1'b1, 1'b1, 1'b0, "reset");
        check_lit("reset_en_fetch", int'(bus.en_fetch), 0);
        check_lit("reset_mem_req", int'(bus.mem_req), 0);
        apply(1'b0, 1'b1, 1'b0, "release");
        check_lit("release_mem_req", int'(bus.mem_req), 0);

        // ALU op with zero-wait memory: 5-cycle stage rotation.
        for (int k = 1; k <= 10; k++) begin
            apply(1'b0, 1'b1, 1'b0, "alu_seq");
            check_lit($sformatf("alu_seq_c%0d", k), stage_vec(), int'(pat[(k - 1) % 5]));
        end

        // LOAD with three wait cycles in MEM.
        bus.opcode = OP_LOAD;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i <= 8; i++) begin
            apply(1'b0, (i >= 4 && i <= 6) ? 1'b0 : 1'b1, 1'b0, "load");
            if (i >= 4 && i <= 7) begin
                cnt_a += int'(bus.mem_req);
                cnt_b += int'(bus.mem_we);
            end
            cnt_c += int'(bus.pc_inc);
            if (i == 8) check_lit("load_wb_regwrite", int'(bus.en_regwrite), 1);
        end
        check_lit("load_req_cycles", cnt_a, 4);
        check_lit("load_mem_we", cnt_b, 0);
        check_lit("load_pc_inc", cnt_c, 1);

        // STORE with one wait cycle in MEM.
        bus.opcode = OP_STORE;
        cnt_a = 0;
        for (int i = 0; i <= 6; i++) begin
            apply(1'b0, (i == 4) ? 1'b0 : 1'b1, 1'b0, "store");
            if (i == 0) begin
                check_lit("model_retired3", int'(m_ret), 3);
`ifdef CTRL_PERF_CNT_EN
                check_lit("retired3", int'(bus.retired), 3);
`endif
            end
            cnt_a += int'(bus.en_regwrite);
            if (i == 4) begin
                check_lit("store_wait_we", int'(bus.mem_we), 1);
                check_lit("store_wait_pc", int'(bus.pc_inc), 0);
            end
            if (i == 5) begin
                check_lit("store_done_pc", int'(bus.pc_inc), 1);
                check_lit("store_done_we", int'(bus.mem_we), 1);
            end
            if (i == 6) check_lit("store_next_fetch", int'(bus.en_fetch), 1);
        end
        check_lit("store_no_regwrite", cnt_a, 0);

        // Reset in the middle of a MEM handshake.
        apply(1'b0, 1'b1, 1'b0, "store2");
        apply(1'b0, 1'b1, 1'b0, "store2");
        apply(1'b0, 1'b1, 1'b0, "store2");
        apply(1'b0, 1'b0, 1'b0, "store2_mem");
        check_lit("mid_mem_req", int'(bus.mem_req), 1);
        apply(1'b1, 1'b1, 1'b0, "mid_mem_reset");
        apply(1'b0, 1'b0, 1'b0, "after_reset");
        check_lit("after_reset_fetch", int'(bus.en_fetch), 0);
        check_lit("after_reset_req", int'(bus.mem_req), 0);
`ifdef CTRL_PERF_CNT_EN
        check_lit("after_reset_retired", int'(bus.retired), 0);
`endif
        apply(1'b0, 1'b0, 1'b0, "refetch");
        check_lit("refetch_en", int'(bus.en_fetch), 1);
        check_lit("refetch_req", int'(bus.mem_req), 1);
        check_lit("refetch_error", int'(bus.error), 0);

        // Fetch timeout: the refetch cycle above was wait 0.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, "tmo_wait");
        apply(1'b0, 1'b0, 1'b0, "tmo_limit");
        check_lit("tmo_limit_halted", int'(bus.halted), 0);
        check_lit("tmo_limit_req", int'(bus.mem_req), 1);
        apply(1'b0, 1'b1, 1'b0, "tmo_halt");
        check_lit("tmo_halted", int'(bus.halted), 1);
        check_lit("tmo_error", int'(bus.error), 1);
        check_lit("tmo_req_off", int'(bus.mem_req), 0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'(i % 2), 1'b0, "tmo_hold");
            cnt_a += int'(bus.halted);
            cnt_b += int'(bus.en_fetch | bus.en_decode | bus.en_regread | bus.en_alu |
                          bus.en_regwrite | bus.mem_req | bus.pc_inc);
        end
        check_lit("tmo_halt_hold", cnt_a, 20);
        check_lit("tmo_halt_quiet", cnt_b, 0);

        // Ready in the limit cycle completes normally.
        bus.opcode = 4'h2;
        apply(1'b1, 1'b0, 1'b0, "lim_reset");
        apply(1'b0, 1'b0, 1'b0, "lim_release");
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 1'b0, "lim_wait");
        apply(1'b0, 1'b1, 1'b0, "lim_ready");
        bus.opcode = OP_HALT;
        apply(1'b0, 1'b0, 1'b0, "lim_decode");
        check_lit("lim_decode_en", int'(bus.en_decode), 1);
        check_lit("lim_no_error", int'(bus.error), 0);

        // HALT opcode: halted from the cycle after REGREAD, immune to mem_ready.
        apply(1'b0, 1'b1, 1'b0, "halt_regread");
        check_lit("halt_regread_en", int'(bus.en_regread), 1);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'(i % 2), 1'b0, "halt_hold");
            cnt_a += int'(bus.halted);
        end
        check_lit("halt_op_hold", cnt_a, 20);
        check_lit("halt_op_no_error", int'(bus.error), 0);

        // Randomized run against the model.
        apply(1'b1, 1'b0, 1'b0, "rand_reset");
        halt_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            rdy_pct = (n < 2000) ? 75 : 45;
            apply(($urandom_range(0, 299) == 0) || (halt_cycles >= 3),
                  $urandom_range(0, 99) < rdy_pct, 1'b1, "random");
            halt_cycles = (m_active && (m_stage == ST_HALT)) ? halt_cycles + 1 : 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
